// File: rtl/regfile_writeback_if.sv
// Writeback bus bundle: ALU and load producer handshakes, register file write port,
// decode hazard queries. qBypass1/qBypass2 exist only with REGFILE_WB_BYPASS_EN.
interface regfile_writeback_if #(
   parameter int N     = 32,
   parameter int DEPTH = 4
);
   logic                   aluValid;
   logic                   aluReady;
   logic [4:0]             aluAddress;
   logic [N-1:0]           aluData;
   logic                   ldValid;
   logic                   ldReady;
   logic [4:0]             ldAddress;
   logic [N-1:0]           ldData;
   logic                   regWrite;
   logic [4:0]             writeAddress;
   logic [N-1:0]           writeData;
   logic [4:0]             qAddress1;
   logic [4:0]             qAddress2;
   logic                   qHazard1;
   logic                   qHazard2;
   logic [$clog2(DEPTH):0] count;
`ifdef REGFILE_WB_BYPASS_EN
   logic [N-1:0]           qBypass1;
   logic [N-1:0]           qBypass2;

   modport master (
      input  aluValid, aluAddress, aluData, ldValid, ldAddress, ldData, qAddress1, qAddress2,
      output aluReady, ldReady, regWrite, writeAddress, writeData, qHazard1, qHazard2, count,
             qBypass1, qBypass2
   );
   modport slave (
      output aluValid, aluAddress, aluData, ldValid, ldAddress, ldData, qAddress1, qAddress2,
      input  aluReady, ldReady, regWrite, writeAddress, writeData, qHazard1, qHazard2, count,
             qBypass1, qBypass2
   );
`else
   modport master (
      input  aluValid, aluAddress, aluData, ldValid, ldAddress, ldData, qAddress1, qAddress2,
      output aluReady, ldReady, regWrite, writeAddress, writeData, qHazard1, qHazard2, count
   );
   modport slave (
      output aluValid, aluAddress, aluData, ldValid, ldAddress, ldData, qAddress1, qAddress2,
      input  aluReady, ldReady, regWrite, writeAddress, writeData, qHazard1, qHazard2, count
   );
`endif
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write-side master: merges ALU results and FIFO-buffered loads onto one
// registered write port and flags pending-write hazards. Option: REGFILE_WB_BYPASS_EN.
module regfile_writeback #(
   parameter int N        = 32,
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 3
) (
   input logic                 clk,
   input logic                 rst,
   regfile_writeback_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int WW = $clog2(MAX_WAIT + 1);

   typedef enum logic [0:0] {PRI = 1'b0, DRAIN = 1'b1} state_t;

   state_t        state_r;
   state_t        state_next_s;
   logic [WW-1:0] wait_r;
   logic [WW-1:0] wait_next_s;

   logic [4:0]    fifo_addr_r [DEPTH];
   logic [N-1:0]  fifo_data_r [DEPTH];
   logic [PW-1:0] head_r;
   logic [PW-1:0] tail_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_next_s;

   logic          reg_write_r;
   logic [4:0]    write_address_r;
   logic [N-1:0]  write_data_r;

   logic          fifo_empty_s;
   logic          alu_ready_s;
   logic          ld_ready_s;
   logic          push_s;
   logic          pop_s;
   logic          alu_grant_s;
   logic          grant_s;
   logic [4:0]    grant_address_s;
   logic [N-1:0]  grant_data_s;
   logic [DEPTH-1:0] entry_valid_s;
   logic          hazard1_s;
   logic          hazard2_s;

   // ldReady looks only at registered occupancy, so a pop never frees a slot in the same cycle
   assign fifo_empty_s = (count_r == {CW{1'b0}});
   assign ld_ready_s   = (count_r < CW'(DEPTH));
   assign alu_ready_s  = (state_r == PRI);
   assign push_s       = bus.ldValid & ld_ready_s & (bus.ldAddress != 5'd0);
   assign count_next_s = count_r + CW'(push_s) - CW'(pop_s);

   always_comb begin
      state_next_s = PRI;
      wait_next_s  = wait_r;
      alu_grant_s  = 1'b0;
      pop_s        = 1'b0;
      case (state_r)
         PRI: begin
            if (bus.aluValid) begin
               alu_grant_s = 1'b1;
               wait_next_s = fifo_empty_s ? {WW{1'b0}} : (wait_r + WW'(1));
            end else if (!fifo_empty_s) begin
               pop_s       = 1'b1;
               wait_next_s = {WW{1'b0}};
            end else begin
               wait_next_s = {WW{1'b0}};
            end
            state_next_s = (wait_next_s == WW'(MAX_WAIT)) ? DRAIN : PRI;
         end
         DRAIN: begin
            pop_s        = !fifo_empty_s;
            wait_next_s  = {WW{1'b0}};
            state_next_s = PRI;
         end
         default: begin
            wait_next_s  = {WW{1'b0}};
            state_next_s = PRI;
         end
      endcase
   end

   // Address-0 ALU results are consumed without a write
   always_comb begin
      grant_s         = 1'b0;
      grant_address_s = write_address_r;
      grant_data_s    = write_data_r;
      if (alu_grant_s) begin
         grant_s         = (bus.aluAddress != 5'd0);
         grant_address_s = bus.aluAddress;
         grant_data_s    = bus.aluData;
      end else if (pop_s) begin
         grant_s         = 1'b1;
         grant_address_s = fifo_addr_r[head_r];
         grant_data_s    = fifo_data_r[head_r];
      end else begin
         grant_s         = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= PRI;
         wait_r  <= {WW{1'b0}};
      end else begin
         state_r <= state_next_s;
         wait_r  <= wait_next_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            fifo_addr_r[i] <= 5'd0;
            fifo_data_r[i] <= {N{1'b0}};
         end
      end else begin
         if (push_s) begin
            fifo_addr_r[tail_r] <= bus.ldAddress;
            fifo_data_r[tail_r] <= bus.ldData;
            tail_r              <= tail_r + PW'(1);
         end
         if (pop_s) begin
            head_r <= head_r + PW'(1);
         end
         count_r <= count_next_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_r     <= 1'b0;
         write_address_r <= 5'd0;
         write_data_r    <= {N{1'b0}};
      end else begin
         reg_write_r <= grant_s;
         if (grant_s) begin
            write_address_r <= grant_address_s;
            write_data_r    <= grant_data_s;
         end
      end
   end

   // An entry is live when its distance from head is below the occupancy
   always_comb begin
      entry_valid_s = {DEPTH{1'b0}};
      hazard1_s     = reg_write_r & (write_address_r == bus.qAddress1);
      hazard2_s     = reg_write_r & (write_address_r == bus.qAddress2);
      for (int i = 0; i < DEPTH; i++) begin
         entry_valid_s[i] = ({1'b0, PW'(i) - head_r} < count_r);
         hazard1_s = hazard1_s | (entry_valid_s[i] & (fifo_addr_r[i] == bus.qAddress1));
         hazard2_s = hazard2_s | (entry_valid_s[i] & (fifo_addr_r[i] == bus.qAddress2));
      end
      hazard1_s = hazard1_s & (bus.qAddress1 != 5'd0);
      hazard2_s = hazard2_s & (bus.qAddress2 != 5'd0);
   end

`ifdef REGFILE_WB_BYPASS_EN
   logic [N-1:0] bypass1_s;
   logic [N-1:0] bypass2_s;

   // Walk head to tail so younger entries override, then let the output stage win
   always_comb begin
      bypass1_s = {N{1'b0}};
      bypass2_s = {N{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         if ((CW'(k) < count_r) && (fifo_addr_r[head_r + PW'(k)] == bus.qAddress1)) begin
            bypass1_s = fifo_data_r[head_r + PW'(k)];
         end else begin
            bypass1_s = bypass1_s;
         end
         if ((CW'(k) < count_r) && (fifo_addr_r[head_r + PW'(k)] == bus.qAddress2)) begin
            bypass2_s = fifo_data_r[head_r + PW'(k)];
         end else begin
            bypass2_s = bypass2_s;
         end
      end
      if (reg_write_r && (write_address_r == bus.qAddress1)) begin
         bypass1_s = write_data_r;
      end else begin
         bypass1_s = bypass1_s;
      end
      if (reg_write_r && (write_address_r == bus.qAddress2)) begin
         bypass2_s = write_data_r;
      end else begin
         bypass2_s = bypass2_s;
      end
      bypass1_s = hazard1_s ? bypass1_s : {N{1'b0}};
      bypass2_s = hazard2_s ? bypass2_s : {N{1'b0}};
   end

   assign bus.qBypass1 = bypass1_s;
   assign bus.qBypass2 = bypass2_s;
`endif

   assign bus.aluReady     = alu_ready_s;
   assign bus.ldReady      = ld_ready_s;
   assign bus.regWrite     = reg_write_r;
   assign bus.writeAddress = write_address_r;
   assign bus.writeData    = write_data_r;
   assign bus.qHazard1     = hazard1_s;
   assign bus.qHazard2     = hazard2_s;
   assign bus.count        = count_r;
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: expected writes queued at issue time, a
// negedge monitor pops and compares every regWrite pulse.
module tb_regfile_writeback;
   localparam int N        = 32;
   localparam int DEPTH    = 4;
   localparam int MAX_WAIT = 3;

   logic clk;
   logic rst;
   int   checks = 0;
   int   passes = 0;
   logic [36:0] exp_q [$];

   regfile_writeback_if #(.N(N), .DEPTH(DEPTH)) bus ();

   regfile_writeback #(.N(N), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
   endtask

   task automatic drive(input logic av, input logic [4:0] aa, input logic [N-1:0] ad,
                        input logic lv, input logic [4:0] la, input logic [N-1:0] ldd);
      bus.aluValid   = av;
      bus.aluAddress = aa;
      bus.aluData    = ad;
      bus.ldValid    = lv;
      bus.ldAddress  = la;
      bus.ldData     = ldd;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [N-1:0] d);
      exp_q.push_back({a, d});
   endtask

   // Scoreboard monitor
   initial begin
      logic [36:0] e;
      forever begin
         @(negedge clk);
         if (!rst && bus.regWrite) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 64'(bus.regWrite), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("sb_write", {27'd0, bus.writeAddress, bus.writeData}, {27'd0, e});
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      idle();
      bus.qAddress1 = 5'd5;
      bus.qAddress2 = 5'd0;
      @(negedge clk);
      #2;
      check("rst_regwrite", 64'(bus.regWrite), 64'd0);
      check("rst_count", 64'(bus.count), 64'd0);
      check("rst_alu_ready", 64'(bus.aluReady), 64'd1);
      check("rst_ld_ready", 64'(bus.ldReady), 64'd1);
      check("rst_hazard1", 64'(bus.qHazard1), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      nxt();

      // ALU-only stream, x0 discarded
      expect_wr(5'd1, 32'h11);
      expect_wr(5'd2, 32'h22);
      drive(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'h0); nxt();
      check("alu_x1_strobe", 64'(bus.regWrite), 64'd1);
      check("alu_x1_addr", 64'(bus.writeAddress), 64'd1);
      drive(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0); nxt();
      check("alu_x2_strobe", 64'(bus.regWrite), 64'd1);
      check("alu_x2_addr", 64'(bus.writeAddress), 64'd2);
      drive(1'b1, 5'd0, 32'h33, 1'b0, 5'd0, 32'h0); nxt();
      idle();
      check("alu_x0_no_write", 64'(bus.regWrite), 64'd0);
      check("alu_count", 64'(bus.count), 64'd0);
      check("alu_x0_hold_data", 64'(bus.writeData), 64'h22);

      // Load latency into empty FIFO
      bus.qAddress1 = 5'd7;
      bus.qAddress2 = 5'd7;
      expect_wr(5'd7, 32'hDEAD);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEAD); nxt();
      idle();
      check("ld_t1_no_write", 64'(bus.regWrite), 64'd0);
      check("ld_t1_hazard1", 64'(bus.qHazard1), 64'd1);
      check("ld_t1_hazard2", 64'(bus.qHazard2), 64'd1);
      check("ld_t1_count", 64'(bus.count), 64'd1);
      nxt();
      check("ld_t2_strobe", 64'(bus.regWrite), 64'd1);
      check("ld_t2_addr", 64'(bus.writeAddress), 64'd7);
      check("ld_t2_hazard1", 64'(bus.qHazard1), 64'd1);
      check("ld_t2_count", 64'(bus.count), 64'd0);
      nxt();
      check("ld_t3_hazard1", 64'(bus.qHazard1), 64'd0);

      // Starvation drain with x9 buffered
      expect_wr(5'd10, 32'hA0);
      expect_wr(5'd11, 32'hA1);
      expect_wr(5'd12, 32'hA2);
      expect_wr(5'd13, 32'hA3);
      expect_wr(5'd9,  32'h99);
      expect_wr(5'd14, 32'hA4);
      drive(1'b1, 5'd10, 32'hA0, 1'b1, 5'd9, 32'h99); nxt();
      check("st_alu_ready_t1", 64'(bus.aluReady), 64'd1);
      drive(1'b1, 5'd11, 32'hA1, 1'b0, 5'd0, 32'h0); nxt();
      drive(1'b1, 5'd12, 32'hA2, 1'b0, 5'd0, 32'h0); nxt();
      drive(1'b1, 5'd13, 32'hA3, 1'b0, 5'd0, 32'h0); nxt();
      check("st_drain_alu_ready", 64'(bus.aluReady), 64'd0);
      check("st_drain_count", 64'(bus.count), 64'd1);
      check("st_drain_prev_write", 64'(bus.writeAddress), 64'd13);
      drive(1'b1, 5'd14, 32'hA4, 1'b0, 5'd0, 32'h0); nxt();
      check("st_resume_alu_ready", 64'(bus.aluReady), 64'd1);
      check("st_x9_addr", 64'(bus.writeAddress), 64'd9);
      check("st_x9_count", 64'(bus.count), 64'd0);
      nxt();
      idle();
      check("st_x14_addr", 64'(bus.writeAddress), 64'd14);

      // Full FIFO with ALU continuously valid
      expect_wr(5'd1,  32'h501);
      expect_wr(5'd2,  32'h502);
      expect_wr(5'd3,  32'h503);
      expect_wr(5'd4,  32'h504);
      expect_wr(5'd20, 32'h200);
      expect_wr(5'd5,  32'h505);
      expect_wr(5'd6,  32'h506);
      expect_wr(5'd7,  32'h507);
      expect_wr(5'd21, 32'h201);
      expect_wr(5'd22, 32'h202);
      expect_wr(5'd23, 32'h203);
      expect_wr(5'd24, 32'h204);
      drive(1'b1, 5'd1, 32'h501, 1'b1, 5'd20, 32'h200); nxt();
      drive(1'b1, 5'd2, 32'h502, 1'b1, 5'd21, 32'h201); nxt();
      drive(1'b1, 5'd3, 32'h503, 1'b1, 5'd22, 32'h202); nxt();
      drive(1'b1, 5'd4, 32'h504, 1'b1, 5'd23, 32'h203); nxt();
      check("full_count", 64'(bus.count), 64'd4);
      check("full_ld_ready", 64'(bus.ldReady), 64'd0);
      check("full_drain_alu_ready", 64'(bus.aluReady), 64'd0);
      drive(1'b1, 5'd5, 32'h505, 1'b1, 5'd24, 32'h204); nxt();
      check("full_after_pop_ld_ready", 64'(bus.ldReady), 64'd1);
      check("full_after_pop_count", 64'(bus.count), 64'd3);
      nxt();
      check("full_refill_count", 64'(bus.count), 64'd4);
      check("full_refill_ld_ready", 64'(bus.ldReady), 64'd0);
      drive(1'b1, 5'd6, 32'h506, 1'b0, 5'd0, 32'h0); nxt();
      drive(1'b1, 5'd7, 32'h507, 1'b0, 5'd0, 32'h0); nxt();
      check("full_drain2_alu_ready", 64'(bus.aluReady), 64'd0);
      idle();
      repeat (5) nxt();
      check("full_empty_count", 64'(bus.count), 64'd0);

      // Two pending writes to x4 in the FIFO
      bus.qAddress1 = 5'd4;
      expect_wr(5'd30, 32'h30);
      expect_wr(5'd31, 32'h31);
      expect_wr(5'd25, 32'h32);
      expect_wr(5'd4,  32'h1);
      expect_wr(5'd4,  32'h2);
      drive(1'b1, 5'd30, 32'h30, 1'b1, 5'd4, 32'h1); nxt();
      drive(1'b1, 5'd31, 32'h31, 1'b1, 5'd4, 32'h2); nxt();
      drive(1'b1, 5'd25, 32'h32, 1'b0, 5'd0, 32'h0);
      #1;
      check("byp_hazard1", 64'(bus.qHazard1), 64'd1);
`ifdef REGFILE_WB_BYPASS_EN
      check("byp_youngest", 64'(bus.qBypass1), 64'h2);
`endif
      nxt();
      idle();
      repeat (3) nxt();
      check("byp_retired_hazard1", 64'(bus.qHazard1), 64'd0);
`ifdef REGFILE_WB_BYPASS_EN
      check("byp_retired_zero", 64'(bus.qBypass1), 64'h0);
`endif

      // Mid-stream asynchronous reset with three loads queued
      bus.qAddress1 = 5'd5;
      expect_wr(5'd26, 32'h40);
      expect_wr(5'd27, 32'h41);
      expect_wr(5'd28, 32'h42);
      drive(1'b1, 5'd26, 32'h40, 1'b1, 5'd5, 32'h55); nxt();
      drive(1'b1, 5'd27, 32'h41, 1'b1, 5'd6, 32'h66); nxt();
      drive(1'b1, 5'd28, 32'h42, 1'b1, 5'd8, 32'h88); nxt();
      idle();
      check("mr_pre_count", 64'(bus.count), 64'd3);
      check("mr_pre_hazard1", 64'(bus.qHazard1), 64'd1);
      check("mr_pre_strobe", 64'(bus.regWrite), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mr_regwrite", 64'(bus.regWrite), 64'd0);
      check("mr_count", 64'(bus.count), 64'd0);
      check("mr_ld_ready", 64'(bus.ldReady), 64'd1);
      check("mr_hazard1", 64'(bus.qHazard1), 64'd0);
      nxt();
      rst = 1'b0;
      nxt();
      check("mr_post_regwrite", 64'(bus.regWrite), 64'd0);
      nxt();
      check("mr_post_regwrite2", 64'(bus.regWrite), 64'd0);

      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
